// File: rtl/gpr_pkg.sv
// gpr_pkg: shared types and constants for the RV64 integer register file.
// Index/word typedefs, debug FSM states, ABI register names for the viewer.
package gpr_pkg;

    parameter int ARCH_WIDTH = 64;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0]  gpr_idx_t;
    typedef logic [ARCH_WIDTH-1:0] gpr_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } dbg_state_t;

    localparam gpr_idx_t REG_ZERO = 5'd0;
    localparam gpr_idx_t REG_RA   = 5'd1;
    localparam gpr_idx_t REG_SP   = 5'd2;
    localparam gpr_idx_t REG_GP   = 5'd3;
    localparam gpr_idx_t REG_TP   = 5'd4;
    localparam gpr_idx_t REG_T0   = 5'd5;
    localparam gpr_idx_t REG_T1   = 5'd6;
    localparam gpr_idx_t REG_T2   = 5'd7;
    localparam gpr_idx_t REG_S0   = 5'd8;
    localparam gpr_idx_t REG_S1   = 5'd9;
    localparam gpr_idx_t REG_A0   = 5'd10;
    localparam gpr_idx_t REG_A1   = 5'd11;
    localparam gpr_idx_t REG_A2   = 5'd12;
    localparam gpr_idx_t REG_A3   = 5'd13;
    localparam gpr_idx_t REG_A4   = 5'd14;
    localparam gpr_idx_t REG_A5   = 5'd15;
    localparam gpr_idx_t REG_A6   = 5'd16;
    localparam gpr_idx_t REG_A7   = 5'd17;
    localparam gpr_idx_t REG_S2   = 5'd18;
    localparam gpr_idx_t REG_S3   = 5'd19;
    localparam gpr_idx_t REG_S4   = 5'd20;
    localparam gpr_idx_t REG_S5   = 5'd21;
    localparam gpr_idx_t REG_S6   = 5'd22;
    localparam gpr_idx_t REG_S7   = 5'd23;
    localparam gpr_idx_t REG_S8   = 5'd24;
    localparam gpr_idx_t REG_S9   = 5'd25;
    localparam gpr_idx_t REG_S10  = 5'd26;
    localparam gpr_idx_t REG_S11  = 5'd27;
    localparam gpr_idx_t REG_T3   = 5'd28;
    localparam gpr_idx_t REG_T4   = 5'd29;
    localparam gpr_idx_t REG_T5   = 5'd30;
    localparam gpr_idx_t REG_T6   = 5'd31;

    function automatic logic is_x0(input gpr_idx_t idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/gpr_file_if.sv
// gpr_file_if: debug access handshake (req/ack) for the register file.
// master = debug host, slave = register file; ARCH_WIDTH sizes data.
interface gpr_file_if #(
    parameter int ARCH_WIDTH = 64
) ();

    logic                  dbgReq;
    logic                  dbgWe;
    logic [4:0]            dbgAddr;
    logic [ARCH_WIDTH-1:0] dbgWData;
    logic                  dbgAck;
    logic [ARCH_WIDTH-1:0] dbgRData;

    modport master (
        output dbgReq,
        output dbgWe,
        output dbgAddr,
        output dbgWData,
        input  dbgAck,
        input  dbgRData
    );

    modport slave (
        input  dbgReq,
        input  dbgWe,
        input  dbgAddr,
        input  dbgWData,
        output dbgAck,
        output dbgRData
    );

endinterface

// File: rtl/gpr_dbg_port.sv
// gpr_dbg_port: debug FSM (IDLE/ACCESS/ACK) serving gpr_file_if requests.
// Ports: clk, rst_n, dbg slave, stall_i, rd_val_i in; wr_req/idx/data out.
module gpr_dbg_port #(
    parameter int ARCH_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gpr_file_if.slave             dbg,
    input  logic                  stall_i,
    input  logic [ARCH_WIDTH-1:0] rd_val_i,
    output logic                  wr_req_o,
    output logic [4:0]            idx_o,
    output logic [ARCH_WIDTH-1:0] wr_data_o
);
    import gpr_pkg::*;

    dbg_state_t            state_q, state_d;
    logic [ARCH_WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // A write waits while the core owns the single write port;
    // a read samples the array and never waits.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        wr_req_o   = 1'b0;
        dbg.dbgAck = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dbg.dbgReq) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!(dbg.dbgWe && stall_i)) begin
                    state_d = ACK;
                    if (dbg.dbgWe) begin
                        wr_req_o = 1'b1;
                    end else begin
                        rdata_d = rd_val_i;
                    end
                end
            end
            ACK: begin
                dbg.dbgAck = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign idx_o        = dbg.dbgAddr;
    assign wr_data_o    = dbg.dbgWData;
    assign dbg.dbgRData = rdata_q;

endmodule

// File: rtl/gpr_file.sv
// gpr_file: RV64 32-entry register file, 2 comb reads, 1 sync write, debug port.
// Ports: clk, rst_n, rs1/rs2 read, rd write, dbg slave, regsData. Opt: GPR_FILE_BYPASS_EN.
module gpr_file #(
    parameter int ARCH_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [4:0]                           rs1Addr,
    output logic [ARCH_WIDTH-1:0]                rs1Data,
    input  logic [4:0]                           rs2Addr,
    output logic [ARCH_WIDTH-1:0]                rs2Data,
    input  logic                                 rdWe,
    input  logic [4:0]                           rdAddr,
    input  logic [ARCH_WIDTH-1:0]                rdData,
    gpr_file_if.slave                            dbg,
    output logic [NUM_REGS-1:0][ARCH_WIDTH-1:0]  regsData
);
    import gpr_pkg::*;

    logic [NUM_REGS-1:0][ARCH_WIDTH-1:0] regs_q, regs_d;

    logic                  dbg_wr;
    gpr_idx_t              dbg_idx;
    logic [ARCH_WIDTH-1:0] dbg_wdata;
    logic [ARCH_WIDTH-1:0] dbg_rval;
    logic                  core_wr;
    logic                  dbg_wr_ok;

    gpr_dbg_port #(
        .ARCH_WIDTH(ARCH_WIDTH)
    ) u_dbg (
        .clk      (clk),
        .rst_n    (rst_n),
        .dbg      (dbg),
        .stall_i  (rdWe),
        .rd_val_i (dbg_rval),
        .wr_req_o (dbg_wr),
        .idx_o    (dbg_idx),
        .wr_data_o(dbg_wdata)
    );

    assign dbg_rval = is_x0(dbg_idx) ? '0 : regs_q[dbg_idx];

    // x0 is never written, so it stays at its reset value of zero.
    assign core_wr   = rdWe && !is_x0(rdAddr);
    assign dbg_wr_ok = dbg_wr && !is_x0(dbg_idx);

    // The debug FSM only issues a write when rdWe is low, so the two
    // sources never collide.
    always_comb begin
        regs_d = regs_q;
        unique case (1'b1)
            core_wr:   regs_d[rdAddr]  = rdData;
            dbg_wr_ok: regs_d[dbg_idx] = dbg_wdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rs1Data = regs_q[rs1Addr];
        rs2Data = regs_q[rs2Addr];
`ifdef GPR_FILE_BYPASS_EN
        if (core_wr && rs1Addr == rdAddr) begin
            rs1Data = rdData;
        end
        if (core_wr && rs2Addr == rdAddr) begin
            rs2Data = rdData;
        end
`endif
    end

    assign regsData = regs_q;

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- RV64 integer register file for the single-cycle core: 32 x ARCH_WIDTH registers, two combinational read ports, one synchronous write port.
- Sits directly upstream of the GPR debug viewer; exports the whole architectural state as a packed array, regsData.
- Adds a debug access port with a req/ack handshake so a testbench or debug host can read and write registers without disturbing core writeback.

Parameters:
- ARCH_WIDTH, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers; fixed at 32 for RV64I, so the index width is 5.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- rs1Addr  in  5  read port 1 index.
- rs1Data  out  ARCH_WIDTH  read port 1 data.
- rs2Addr  in  5  read port 2 index.
- rs2Data  out  ARCH_WIDTH  read port 2 data.
- rdWe  in  1  core writeback enable.
- rdAddr  in  5  core writeback index.
- rdData  in  ARCH_WIDTH  core writeback data.
- dbgReq  in  1  debug request; held high until dbgAck.
- dbgWe  in  1  debug op: 1 = write, 0 = read; stable while dbgReq is high.
- dbgAddr  in  5  debug register index; stable while dbgReq is high.
- dbgWData  in  ARCH_WIDTH  debug write data.
- dbgAck  out  1  one-cycle completion pulse.
- dbgRData  out  ARCH_WIDTH  debug read data; valid in the dbgAck cycle.
- regsData  out  [31:0][ARCH_WIDTH-1:0]  all registers, packed, for the GPR debug viewer.

Behaviour:
- Reset: while rst_n is low at a clk edge, all 32 registers clear to 0.
  - Debug FSM returns to IDLE.
  - dbgAck = 0, dbgRData = 0.
  - Reset takes priority over every write in the same cycle.
- x0: reads as 0 on every path (rs1, rs2, dbgRData, regsData[0]). Writes to index 0 from either source are dropped; the debug write still acks.
- Reads: rs1Data and rs2Data are combinational from current register contents; zero latency.
- Core write: when rdWe = 1 and rdAddr != 0, the register updates at the clk edge. The new value is visible on reads and on regsData the following cycle.
- Debug FSM states: IDLE, ACCESS, ACK.
  - IDLE -> ACCESS when dbgReq = 1.
  - ACCESS:
    - If rdWe = 1 and this is a write (dbgWe = 1), the debug op stalls in ACCESS; the core always has the single write port.
    - Otherwise the op executes:
      - write: the register takes dbgWData at the edge.
      - read: dbgRData is registered from the current register value, or 0 for x0.
    - Then -> ACK.
    - A debug read never stalls.
  - ACK: dbgAck = 1 for exactly one cycle, then -> IDLE.
    - If dbgReq is still high in IDLE, it is treated as a new request; the host must drop dbgReq on seeing dbgAck.
  - Worst-case latency while the core is not writing: 3 cycles from req to ack.
- dbgRData holds its last value outside the ACK cycle.
- Reset mid-transaction: the FSM aborts to IDLE, no ack is produced, and a pending write is discarded.
- Same-cycle core write and debug read of the same register: the debug read returns the pre-write value.

Optional Feature:
- Macro GPR_FILE_BYPASS_EN.
- Defined: write-through forwarding. When rdWe = 1, rdAddr != 0 and rsNAddr == rdAddr, rsNData returns rdData in the same cycle.
- Undefined: reads return stored contents only; a same-cycle write is seen next cycle.
- regsData is never bypassed in either configuration.

Decomposition:
- Shared package gpr_pkg holds:
  - REG_IDX_W = 5 and NUM_REGS = 32.
  - typedef gpr_idx_t.
  - typedef gpr_word_t, with ARCH_WIDTH passed via the package parameter default of 64.
  - enum dbg_state_t (IDLE, ACCESS, ACK).
  - ABI-name localparams (REG_SP = 2, REG_A0 = 10, etc.), reused by the debug viewer.
- One natural sub-module, gpr_dbg_port: the debug FSM. It outputs a write-request/index/data triple plus a stall input, which the storage arbitrates.

Test Plan:
- Reset: write x5 = 0xDEAD, assert rst_n = 0 for one edge -> rs1Data (rs1Addr = 5) = 0, regsData[5] = 0, dbgAck = 0.
- x0: rdWe = 1, rdAddr = 0, rdData = 0xFFFF_FFFF_FFFF_FFFF -> next cycle rs1Data (addr 0) = 0 and regsData[0] = 0.
- Dual read: write x1 = 0x1111, x2 = 0x2222; rs1Addr = 1, rs2Addr = 2 -> rs1Data = 0x1111, rs2Data = 0x2222 in the same cycle.
- Debug write under contention: dbgReq with dbgWe = 1, addr 10, data 0xA0; hold rdWe = 1 for 4 cycles -> no ack while rdWe is high; ack 2 cycles after rdWe drops; regsData[10] = 0xA0.
- Debug read: x3 = 0x33; debug read of addr 3 -> dbgAck pulses at cycle 3, dbgRData = 0x33; dbgAck is high for exactly 1 cycle.
- Bypass: write x7 = 0x77 with rs1Addr = 7 in the same cycle -> rs1Data = 0x77 that cycle with GPR_FILE_BYPASS_EN, otherwise the old value; regsData[7] updates only on the next cycle in both builds.
